// File: rtl/param_cache_line_if.sv
// Bundle of the CPU, refill, writeback and status signals of one cache line.
// The line itself attaches through the slave modport; the cache controller
// (or a testbench) drives it through the master modport.
interface param_cache_line_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned TAG_W  = 25
);

  localparam int unsigned IW = $clog2(WORDS);
  localparam int unsigned BE = WORD_W / 8;

  // CPU access
  logic              line_sel;
  logic [TAG_W-1:0]  tag_in;
  logic [IW-1:0]     word_idx;
  logic              wr_en;
  logic [BE-1:0]     wr_be;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] rd_data;
  logic              hit;

  // Refill
  logic              fill_start;
  logic [TAG_W-1:0]  fill_tag;
  logic              fill_valid;
  logic [WORD_W-1:0] fill_data;
  logic              fill_ready;

  // Writeback
  logic              evict_start;
  logic              wb_valid;
  logic              wb_ready;
  logic [WORD_W-1:0] wb_data;
  logic [IW-1:0]     wb_idx;
  logic [TAG_W-1:0]  wb_tag;

  // Maintenance and status
  logic              inval;
  logic              valid_out;
  logic              dirty_out;
  logic              busy;
  logic              done;

  modport master (
    output line_sel, tag_in, word_idx, wr_en, wr_be, wr_data,
    output fill_start, fill_tag, fill_valid, fill_data,
    output evict_start, wb_ready, inval,
    input  rd_data, hit, fill_ready, wb_valid, wb_data, wb_idx, wb_tag,
    input  valid_out, dirty_out, busy, done
  );

  modport slave (
    input  line_sel, tag_in, word_idx, wr_en, wr_be, wr_data,
    input  fill_start, fill_tag, fill_valid, fill_data,
    input  evict_start, wb_ready, inval,
    output rd_data, hit, fill_ready, wb_valid, wb_data, wb_idx, wb_tag,
    output valid_out, dirty_out, busy, done
  );

endinterface

// File: rtl/param_cache_line.sv
// One cache line: tag, valid/dirty state, a WORDS-deep data array with
// byte-masked CPU writes, a streaming refill port and a streaming writeback
// port. A small FSM (idle / fill / evict) sequences the bursts with a shared
// word counter.
module param_cache_line #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned TAG_W  = 25
) (
  input logic                clk,
  input logic                reset,
  param_cache_line_if.slave  bus
);

  localparam int unsigned   IW      = $clog2(WORDS);
  localparam int unsigned   BE      = WORD_W / 8;
  localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StEvict
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              dirty_q, dirty_d;
  logic              done_q, done_d;
  logic [TAG_W-1:0]  tag_q;
  logic [WORD_W-1:0] data_q [WORDS];

  // Single write port into the data array, shared by CPU writes and refill.
  logic              tag_we;
  logic              data_we;
  logic [IW-1:0]     data_widx;
  logic [WORD_W-1:0] data_wdata;
  logic [BE-1:0]     data_wbe;

  logic              hit;

  assign hit = bus.line_sel & valid_q & (bus.tag_in == tag_q);

  // Next-state decode; priority in idle is evict > fill > inval > CPU write.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    done_d     = 1'b0;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_widx  = bus.word_idx;
    data_wdata = bus.wr_data;
    data_wbe   = bus.wr_be;

    unique case (state_q)
      StIdle: begin
        if (bus.line_sel && bus.evict_start) begin
          if (valid_q && dirty_q) begin
            cnt_d   = '0;
            state_d = StEvict;
          end else begin
            // Nothing to write back: acknowledge immediately.
            done_d = 1'b1;
          end
        end else if (bus.line_sel && bus.fill_start) begin
          tag_we  = 1'b1;
          valid_d = 1'b0;
          dirty_d = 1'b0;
          cnt_d   = '0;
          state_d = StFill;
        end else if (bus.inval) begin
          valid_d = 1'b0;
          dirty_d = 1'b0;
        end else if (bus.wr_en && hit) begin
          data_we = 1'b1;
          // An all-zero byte mask modifies nothing, so it must not dirty the line.
          if (|bus.wr_be) begin
            dirty_d = 1'b1;
          end
        end
      end

      StFill: begin
        if (bus.fill_valid) begin
          data_we    = 1'b1;
          data_widx  = cnt_q;
          data_wdata = bus.fill_data;
          data_wbe   = '1;
          if (cnt_q == LastIdx) begin
            valid_d = 1'b1;
            dirty_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StEvict: begin
        if (bus.wb_ready) begin
          if (cnt_q == LastIdx) begin
            dirty_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state; reset abandons any burst and leaves the line invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      done_q  <= done_d;
    end
  end

  // Tag storage; deliberately not reset, validity is carried by valid_q.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q <= bus.fill_tag;
    end
  end

  // Data array with per-byte write enables; not reset.
  always_ff @(posedge clk) begin
    if (data_we) begin
      for (int b = 0; b < BE; b++) begin
        if (data_wbe[b]) begin
          data_q[data_widx][b*8 +: 8] <= data_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign bus.rd_data    = data_q[bus.word_idx];
  assign bus.hit        = hit;
  assign bus.fill_ready = (state_q == StFill);
  assign bus.wb_valid   = (state_q == StEvict);
  assign bus.wb_data    = data_q[cnt_q];
  assign bus.wb_idx     = cnt_q;
  assign bus.wb_tag     = tag_q;
  assign bus.valid_out  = valid_q;
  assign bus.dirty_out  = dirty_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;

endmodule

// File: doc/param_cache_line.md
PARAM_CACHE_LINE -- requirements
Module: param_cache_line

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data word width in bits; multiple of 8.
REQ-002 SHALL have parameter WORDS, default 16, words per line; power of two, 2 or more.
REQ-003 SHALL have parameter TAG_W, default 25, tag width in bits.
REQ-004 SHALL have ports, one per line (IW = clog2(WORDS), BE = WORD_W/8):
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- line_sel  in  1  line addressed by the set/way decode.
- tag_in  in  TAG_W  lookup tag.
- word_idx  in  IW  word offset for CPU read/write.
- wr_en  in  1  CPU word-write request.
- wr_be  in  BE  byte enables for wr_en.
- wr_data  in  WORD_W  CPU write data.
- rd_data  out  WORD_W  data[word_idx], combinational.
- hit  out  1  line_sel & valid & (tag_in == tag_q).
- fill_start  in  1  begin refill.
- fill_tag  in  TAG_W  tag for the refill.
- fill_valid  in  1  fill word present.
- fill_data  in  WORD_W  fill word.
- fill_ready  out  1  line accepts fill words.
- evict_start  in  1  begin writeback.
- wb_valid  out  1  writeback word present.
- wb_ready  in  1  downstream accepts the writeback word.
- wb_data  out  WORD_W  data[cnt].
- wb_idx  out  IW  index of the current writeback word.
- wb_tag  out  TAG_W  tag_q.
- inval  in  1  invalidate the line.
- valid_out  out  1  valid bit.
- dirty_out  out  1  dirty bit.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a fill or eviction completes.

Function
REQ-005 SHALL hold a state machine with states IDLE, FILL and EVICT, plus an IW-bit word counter cnt.
REQ-006 SHALL accept start commands only in IDLE when line_sel=1; start commands at any other time SHALL be ignored.
REQ-007 SHALL, for CPU write in IDLE with wr_en & hit, update at the next edge only the bytes of data[word_idx] with wr_be=1 and set dirty=1.
REQ-008 SHALL leave all data bytes and dirty unchanged when wr_be=0; a write in IDLE still requires hit.
REQ-009 SHALL ignore wr_en when not in IDLE or when hit=0.
REQ-010 SHALL, on fill_start in IDLE, capture tag_q = fill_tag, clear valid and dirty, set cnt=0, and enter FILL.
REQ-011 SHALL drive fill_ready=1 in FILL; each cycle with fill_valid=1 SHALL write data[cnt]=fill_data and increment cnt.
REQ-012 SHALL, on the fill handshake at cnt=WORDS-1, set valid=1 and dirty=0, pulse done, and return to IDLE with cnt=0.
REQ-013 SHALL start eviction on evict_start in IDLE only when valid=1 and dirty=1: cnt=0, enter EVICT.
REQ-014 SHALL otherwise treat evict_start in IDLE as a no-op that still pulses done next cycle.
REQ-015 SHALL drive wb_valid=1 in EVICT; wb_data, wb_idx and wb_tag SHALL stay stable until the handshake (wb_valid & wb_ready), after which cnt increments.
REQ-016 SHALL, on the eviction handshake at cnt=WORDS-1, clear dirty (valid unchanged), pulse done, and return to IDLE.
REQ-017 SHALL give evict_start priority over fill_start when both are asserted in the same IDLE cycle; fill_start is then dropped.
REQ-018 SHALL give fill_start and evict_start priority over inval, and inval over wr_en, in the same cycle.
REQ-019 SHALL, on inval in IDLE, clear valid and dirty with data and tag unchanged; inval when not in IDLE SHALL be ignored.
REQ-020 SHALL count cnt modulo WORDS with no overflow beyond WORDS-1; stall cycles (no handshake) SHALL hold cnt.

Reset
REQ-021 SHALL, while reset=0, asynchronously force state=IDLE, cnt=0, valid=0, dirty=0, done=0, fill_ready=0 and wb_valid=0; tag_q and data are not reset.
REQ-022 SHALL abandon a fill or eviction interrupted by reset, leaving the line invalid, with no done pulse.

Verification
REQ-023 Fill: fill_start with fill_tag=0x0ABCDEF, then 16 words k=0..15 with fill_data=0x1000+k, fill_valid gapped every third cycle -> done on the last word, valid=1, dirty=0, hit=1 for tag 0x0ABCDEF, rd_data at idx 5 = 0x1005.
REQ-024 Byte write: hit, idx 3, wr_be=4'b0101, wr_data=0xAABBCCDD over 0x1003 -> data[3]=0x00BB10DD, dirty=1; the same write with a wrong tag -> no change.
REQ-025 Evict: dirty line, evict_start, wb_ready toggling 1,0,1,... -> 16 handshakes in idx order 0..15 with stable data during stalls, then done, dirty=0, valid=1.
REQ-026 Collision: fill_start, evict_start and wr_en in the same cycle on a dirty line -> EVICT entered, fill ignored, data unchanged; evict_start on a clean line -> done with no wb_valid.
REQ-027 Reset mid-op: reset=0 asserted after 7 fill words, asynchronously between edges -> busy, valid and fill_ready drop immediately; after release, IDLE and hit=0.
REQ-028 Parameters: repeat REQ-023 and REQ-025 with WORD_W=64, WORDS=4, TAG_W=20 -> 4-beat transfers, 8-bit wr_be honoured.
